fm_receiver_axil_master: RTL and testbench

FM_RECEIVER_AXIL_MASTER -- requirements
Module: fm_receiver_axil_master

---
 rtl/fm_receiver_axil_pkg.sv | 19 +
 rtl/fm_receiver_axil_master.sv | 162 ++++++++++++++++
 tb/tb_fm_receiver_axil_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_receiver_axil_pkg.sv
// Shared types and constants for the FM receiver AXI-Lite register master.
package fm_receiver_axil_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/fm_receiver_axil_master.sv
// Single-outstanding AXI-Lite master: turns one cmd_* request into an AXI
// write or read and returns the captured data/response on rsp_*.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered; each drops after its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_DATA | RREADY high, waiting for RVALID
// RSP     | rsp_valid high, result held until rsp_ready
module fm_receiver_axil_master
    import fm_receiver_axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 6
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    input  logic [STRB_WIDTH-1:0]         cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [DATA_WIDTH-1:0]         WDATA,
    output logic [STRB_WIDTH-1:0]         WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] WORD_MASK =
        {{(C_M_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                        state;
    state_t                        state_nxt;
    logic                          aw_done;
    logic                          w_done;
    logic                          aw_hs;
    logic                          w_hs;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]         wdata_q;
    logic [STRB_WIDTH-1:0]         wstrb_q;

    // Handshakes decoded from state so the FSM never loops through its own outputs.
    assign aw_hs = (state == WR_REQ) && !aw_done && AWREADY;
    assign w_hs  = (state == WR_REQ) && !w_done  && WREADY;

    assign AWADDR = addr_q & WORD_MASK;
    assign ARADDR = addr_q & WORD_MASK;
    assign WDATA  = wdata_q;
    assign WSTRB  = wstrb_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                AWVALID = !aw_done;
                WVALID  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    state_nxt = RSP;
                end
            end
            RD_REQ: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            if ((state == IDLE) && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if ((state == WR_RESP) && BVALID) begin
                rsp_rdata <= '0;
                rsp_resp  <= BRESP;
            end
            if ((state == RD_DATA) && RVALID) begin
                rsp_rdata <= RDATA;
                rsp_resp  <= RRESP;
            end
        end
    end

endmodule

// File: tb/tb_fm_receiver_axil_master.sv
// Bench for fm_receiver_axil_master: memory-backed AXI-Lite responder with
// programmable waits, plus a word-array reference model of the register space.
module tb_fm_receiver_axil_master;
    import fm_receiver_axil_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    always #5 ACLK = ~ACLK;

    fm_receiver_axil_master #(.C_M_AXI_ADDR_WIDTH(6)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;

    // responder knobs and per-transaction expectations, written by the main process only
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0]  b_resp, r_resp;
    logic [5:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] model_mem [16];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}),
              64'(7'b1000000));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_resp"}, 64'(rsp_resp), 64'd0);
    endtask

    task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [1:0] br, input logic [1:0] rr);
        aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
        b_resp = br; r_resp = rr;
    endtask

    // AXI-Lite slave; drives at the falling edge so every handshake is decided before the rising edge
    initial begin : responder
        int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit          aw_got, w_got, ar_got;
        bit          aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
        logic [5:0]  s_awaddr, s_araddr;
        logic [31:0] s_wdata, mask;
        logic [3:0]  s_wstrb;
        logic [31:0] slv_mem [16];
        for (int i = 0; i < 16; i++) slv_mem[i] = 32'h0101_0101 * i;
        slv_mem[10] = 32'hDEAD_BEEF;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
        s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0; mask = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
                continue;
            end
            if (b_hs_p) begin
                BVALID = 0; aw_got = 0; w_got = 0; b_cnt = 0;
            end
            if (BREADY) check("bready_after_aw_w", 64'(aw_got && w_got), 64'd1);
            if (!BVALID && aw_got && w_got) begin
                if (b_cnt >= b_wait) begin
                    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s_wstrb[b]}};
                    slv_mem[s_awaddr[5:2]] = (slv_mem[s_awaddr[5:2]] & ~mask) | (s_wdata & mask);
                    BVALID = 1; BRESP = b_resp;
                end else b_cnt++;
            end
            b_hs_p = BVALID && BREADY;

            if (aw_hs_p) check("awvalid_drop", 64'(AWVALID), 64'd0);
            aw_hs_p = 0; AWREADY = 0;
            if (AWVALID && !aw_got) begin
                check("awaddr", 64'(AWADDR), 64'(exp_addr));
                if (aw_cnt >= aw_wait) begin
                    AWREADY = 1; aw_hs_p = 1; aw_got = 1; s_awaddr = AWADDR; aw_cnt = 0;
                end else aw_cnt++;
            end

            if (w_hs_p) check("wvalid_drop", 64'(WVALID), 64'd0);
            w_hs_p = 0; WREADY = 0;
            if (WVALID && !w_got) begin
                check("wdata", 64'(WDATA), 64'(exp_wdata));
                check("wstrb", 64'(WSTRB), 64'(exp_wstrb));
                if (w_cnt >= w_wait) begin
                    WREADY = 1; w_hs_p = 1; w_got = 1; s_wdata = WDATA; s_wstrb = WSTRB; w_cnt = 0;
                end else w_cnt++;
            end

            if (r_hs_p) begin
                RVALID = 0; ar_got = 0; r_cnt = 0;
            end
            if (RREADY) check("rready_after_ar", 64'(ar_got), 64'd1);
            if (!RVALID && ar_got) begin
                if (r_cnt >= r_wait) begin
                    RVALID = 1; RDATA = slv_mem[s_araddr[5:2]]; RRESP = r_resp;
                end else r_cnt++;
            end
            r_hs_p = RVALID && RREADY;

            if (ar_hs_p) check("arvalid_drop", 64'(ARVALID), 64'd0);
            ar_hs_p = 0; ARREADY = 0;
            if (ARVALID && !ar_got) begin
                check("araddr", 64'(ARADDR), 64'(exp_addr));
                if (ar_cnt >= ar_wait) begin
                    ARREADY = 1; ar_hs_p = 1; ar_got = 1; s_araddr = ARADDR; ar_cnt = 0;
                end else ar_cnt++;
            end
        end
    end

    task automatic wait_cmd_accept();
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        @(negedge ACLK);
        cmd_valid = 0;
    endtask

    // one full command -> response round trip, expectations from the word-array model
    task automatic do_txn(input logic wr, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, input bit chk_lat, input bit pend);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          n;
        exp_addr  = {a[5:2], 2'b00};
        exp_wdata = d;
        exp_wstrb = s;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
            exp_data = 32'd0;
            exp_resp = b_resp;
        end else begin
            exp_data = model_mem[a[5:2]];
            exp_resp = r_resp;
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        wait_cmd_accept();
        n = 1;
        while (!rsp_valid && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        if (chk_lat) check("latency", 64'(n), 64'd3);
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_data));
        check("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                cmd_valid = 1; cmd_write = 1'($urandom); cmd_addr = 6'($urandom);
                cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end
            @(negedge ACLK);
            check("hold_state", 64'({rsp_valid, cmd_ready}), 64'(2'b10));
            check("hold_rdata", 64'(rsp_rdata), 64'(exp_data));
            check("hold_resp", 64'(rsp_resp), 64'(exp_resp));
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        check("back_to_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    endtask

    initial begin : main
        bit          zw, saw;
        int          n;
        logic        r_wr;
        logic [1:0]  r_br, r_rr;
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        set_cfg(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0101_0101 * i;
        model_mem[10] = 32'hDEAD_BEEF;

        repeat (3) @(negedge ACLK);
        check_reset("reset");
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);

        // zero-wait write, then read it back
        do_txn(1'b1, 6'h10, 32'h5, 4'hF, 0, 1'b1, 1'b0);
        do_txn(1'b0, 6'h12, 32'h0, 4'h0, 0, 1'b1, 1'b0);
        // read with four wait cycles on R
        set_cfg(0, 0, 0, 0, 4, RESP_OKAY, RESP_OKAY);
        do_txn(1'b0, 6'h2B, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        // W accepted three cycles before AW, error response passed through
        set_cfg(3, 0, 0, 0, 0, RESP_SLVERR, RESP_OKAY);
        do_txn(1'b1, 6'h04, 32'hA5A5_0F0F, 4'b0101, 0, 1'b0, 1'b0);
        // back-pressured response with a command waiting
        set_cfg(0, 0, 0, 0, 0, RESP_OKAY, RESP_SLVERR);
        do_txn(1'b0, 6'h28, 32'h0, 4'h0, 5, 1'b1, 1'b1);

        // reset while waiting for read data
        set_cfg(0, 0, 0, 0, 10, RESP_OKAY, RESP_OKAY);
        exp_addr = 6'h30;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 6'h31;
        wait_cmd_accept();
        n = 0;
        while (!RREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("rd_data_reached", 64'(RREADY), 64'd1);
        ARESET = 1;
        @(negedge ACLK);
        check_reset("mid_reset");
        @(negedge ACLK);
        ARESET = 0;
        saw = 0;
        repeat (20) begin
            @(negedge ACLK);
            if (rsp_valid || !cmd_ready) saw = 1;
        end
        check("no_rsp_after_reset", 64'(saw), 64'd0);

        set_cfg(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
        do_txn(1'b1, 6'h3C, 32'h1234_5678, 4'b1100, 0, 1'b1, 1'b0);
        do_txn(1'b0, 6'h3D, 32'h0, 4'h0, 0, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            zw   = ($urandom_range(0, 3) == 0);
            r_wr = 1'($urandom);
            r_br = 2'($urandom);
            r_rr = 2'($urandom);
            if (zw) set_cfg(0, 0, 0, 0, 0, r_br, r_rr);
            else set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), r_br, r_rr);
            do_txn(r_wr, 6'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                   zw, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
